// File: rtl/addsub_iter.sv
// rtl/addsub_iter.sv - iterative chunk-serial unsigned adder/subtractor with valid/ready handshake.
// Optional unsigned saturation of the result is enabled by defining ADDSUB_ITER_SAT_EN.
module addsub_iter #(
    parameter int DATA_SIZE  = 16,
    parameter int CHUNK_SIZE = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [DATA_SIZE-1:0] a1,
    input  logic [DATA_SIZE-1:0] b,
    input  logic                 cin,
    input  logic                 operation,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [DATA_SIZE-1:0] s,
    output logic                 cout,
    output logic                 busy
);

    localparam int NCHUNK = DATA_SIZE / CHUNK_SIZE;
    localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [CW-1:0] LAST_CHUNK = CW'(NCHUNK - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [DATA_SIZE-1:0] a_q, a_d;
    logic [DATA_SIZE-1:0] b_q, b_d;
    logic                 carry_q, carry_d;
    logic [DATA_SIZE-1:0] s_q, s_d;
    logic                 cout_q, cout_d;
`ifdef ADDSUB_ITER_SAT_EN
    logic                 op_q, op_d;
`endif

    int                   base;
    logic [CHUNK_SIZE:0]  chunk_sum;

    always_comb begin
        base      = int'(cnt_q) * CHUNK_SIZE;
        chunk_sum = {1'b0, a_q[base +: CHUNK_SIZE]} + {1'b0, b_q[base +: CHUNK_SIZE]}
                  + {{CHUNK_SIZE{1'b0}}, carry_q};

        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        carry_d = carry_q;
        s_d     = s_q;
        cout_d  = cout_q;
`ifdef ADDSUB_ITER_SAT_EN
        op_d    = op_q;
`endif

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = a1;
                    b_d     = operation ? b : ~b;
                    carry_d = cin;
                    cnt_d   = '0;
                    state_d = BUSY;
`ifdef ADDSUB_ITER_SAT_EN
                    op_d    = operation;
`endif
                end
            end
            BUSY: begin
                s_d[base +: CHUNK_SIZE] = chunk_sum[CHUNK_SIZE-1:0];
                carry_d = chunk_sum[CHUNK_SIZE];
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == LAST_CHUNK) begin
                    cnt_d   = '0;
                    cout_d  = chunk_sum[CHUNK_SIZE];
                    state_d = DONE;
`ifdef ADDSUB_ITER_SAT_EN
                    // cout keeps the raw carry; only s is clamped
                    if (op_q && chunk_sum[CHUNK_SIZE]) begin
                        s_d = '1;
                    end else if (!op_q && !chunk_sum[CHUNK_SIZE]) begin
                        s_d = '0;
                    end
`endif
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            s_q     <= '0;
            cout_q  <= 1'b0;
`ifdef ADDSUB_ITER_SAT_EN
            op_q    <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            carry_q <= carry_d;
            s_q     <= s_d;
            cout_q  <= cout_d;
`ifdef ADDSUB_ITER_SAT_EN
            op_q    <= op_d;
`endif
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign busy      = (state_q == BUSY);
    assign out_valid = (state_q == DONE);
    assign s         = s_q;
    assign cout      = cout_q;

endmodule

// File: tb/tb_addsub_iter.sv
// tb/tb_addsub_iter.sv - self-checking bench for addsub_iter (16-bit data, 4-bit chunks).
module tb_addsub_iter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] a1 = '0;
    logic [15:0] b = '0;
    logic        cin = 1'b0;
    logic        operation = 1'b1;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] s;
    logic        cout;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;

    logic [15:0] exp_s = '0;
    logic        exp_c = 1'b0;
    logic        exp_valid = 1'b0;

    addsub_iter #(.DATA_SIZE(16), .CHUNK_SIZE(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a1(a1), .b(b), .cin(cin), .operation(operation),
        .out_valid(out_valid), .out_ready(out_ready),
        .s(s), .cout(cout), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [16:0] model(input logic [15:0] a, input logic [15:0] bb,
                                          input logic c, input logic op);
        logic [16:0] sum;
        sum = {1'b0, a} + {1'b0, (op ? bb : ~bb)} + {16'd0, c};
`ifdef ADDSUB_ITER_SAT_EN
        if (op && sum[16])   sum[15:0] = 16'hFFFF;
        if (!op && !sum[16]) sum[15:0] = 16'h0000;
`endif
        return sum;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
        end
    endtask

    // Result checker: whenever a result is presented it must match the model.
    always @(negedge clk) begin
        if (!rst && out_valid) begin
            check("outvalid_expected", {31'd0, exp_valid}, 32'd1);
            check("s_model", {16'd0, s}, {16'd0, exp_s});
            check("cout_model", {31'd0, cout}, {31'd0, exp_c});
            check("ready_vs_valid", {31'd0, in_ready}, 32'd0);
        end
    end

    // Called just after a negedge in IDLE; returns at a negedge back in IDLE.
    task automatic run_op(input logic [15:0] a, input logic [15:0] bb, input logic c,
                          input logic op, input int stall,
                          output logic [15:0] rs, output logic rc);
        logic [16:0] m;
        int lat;
        check("in_ready_before", {31'd0, in_ready}, 32'd1);
        a1 = a; b = bb; cin = c; operation = op; in_valid = 1'b1;
        m = model(a, bb, c, op);
        exp_s = m[15:0]; exp_c = m[16]; exp_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("busy_after_accept", {31'd0, busy}, 32'd1);
        a1 = 16'($urandom); b = 16'($urandom); cin = ~c; operation = ~op;
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check("latency", lat, 32'd4);
        rs = s; rc = cout;
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            in_valid = i[0];
            check("bp_in_ready", {31'd0, in_ready}, 32'd0);
            check("bp_s_stable", {16'd0, s}, {16'd0, rs});
            check("bp_cout_stable", {31'd0, cout}, {31'd0, rc});
        end
        @(negedge clk);
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("back_to_idle", {30'd0, out_valid, in_ready}, 32'd1);
        check("s_retained", {16'd0, s}, {16'd0, rs});
        exp_valid = 1'b0;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    initial begin
        logic [15:0] rs;
        logic        rc;
        int          hits[$];
        int          wait_cnt;

        #1;
        check("rst_s", {16'd0, s}, 32'd0);
        check("rst_flags", {28'd0, cout, out_valid, busy, in_ready}, 32'd1);
        @(negedge clk); @(negedge clk);
        rst = 1'b0;

        // First edge after release accepts.
        run_op(16'h1234, 16'h0FFF, 1'b0, 1'b1, 0, rs, rc);
        check("lit_add_s", {16'd0, rs}, 32'h2233);
        check("lit_add_c", {31'd0, rc}, 32'd0);

        run_op(16'hFFFF, 16'h0001, 1'b0, 1'b1, 0, rs, rc);
        check("lit_ovf_c", {31'd0, rc}, 32'd1);
`ifdef ADDSUB_ITER_SAT_EN
        check("lit_ovf_s", {16'd0, rs}, 32'hFFFF);
`else
        check("lit_ovf_s", {16'd0, rs}, 32'h0000);
`endif

        run_op(16'h0005, 16'h0007, 1'b1, 1'b0, 0, rs, rc);
        check("lit_borrow_c", {31'd0, rc}, 32'd0);
`ifdef ADDSUB_ITER_SAT_EN
        check("lit_borrow_s", {16'd0, rs}, 32'h0000);
`else
        check("lit_borrow_s", {16'd0, rs}, 32'hFFFE);
`endif

        run_op(16'h0007, 16'h0005, 1'b1, 1'b0, 10, rs, rc);
        check("lit_sub_s", {16'd0, rs}, 32'h0002);
        check("lit_sub_c", {31'd0, rc}, 32'd1);

        // Assorted vectors, checked against the model by the result checker.
        run_op(16'hA5A5, 16'h5A5A, 1'b1, 1'b1, 2, rs, rc);
        run_op(16'h8000, 16'h8000, 1'b0, 1'b1, 0, rs, rc);
        run_op(16'h0000, 16'h0000, 1'b0, 1'b0, 1, rs, rc);
        run_op(16'h1000, 16'h0FFF, 1'b0, 1'b0, 0, rs, rc);
        run_op(16'h000F, 16'h0001, 1'b0, 1'b1, 0, rs, rc);
        check("lit_ripple_s", {16'd0, rs}, 32'h0010);

        // Reset two edges into BUSY aborts the operation.
        a1 = 16'h4321; b = 16'h1111; cin = 1'b0; operation = 1'b1; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b1;
        exp_valid = 1'b0;
        #1;
        check("abort_s", {16'd0, s}, 32'd0);
        check("abort_flags", {28'd0, cout, out_valid, busy, in_ready}, 32'd1);
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        run_op(16'h0001, 16'h0001, 1'b0, 1'b1, 0, rs, rc);
        check("lit_after_rst", {16'd0, rs}, 32'h0002);

        // Back-to-back throughput with out_ready held high.
        a1 = 16'h0003; b = 16'h0004; cin = 1'b0; operation = 1'b1;
        exp_s = 16'h0007; exp_c = 1'b0; exp_valid = 1'b1;
        in_valid = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (in_ready) hits.push_back(i);
            @(negedge clk);
        end
        in_valid = 1'b0;
        check("tput_count", hits.size(), 32'd4);
        if (hits.size() >= 3) begin
            check("tput_period0", hits[1] - hits[0], 32'd6);
            check("tput_period1", hits[2] - hits[1], 32'd6);
        end
        wait_cnt = 0;
        while (!in_ready && wait_cnt < 20) begin
            @(negedge clk);
            wait_cnt++;
        end
        check("drain_idle", {31'd0, in_ready}, 32'd1);
        out_ready = 1'b0;
        exp_valid = 1'b0;
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
